// File: rtl/hilo_mult_sequencer.sv
// Purpose: MIPS-style HI/LO unit: iterative 32x32 multiply (mult/multu/madd/msub) plus mthi/mtlo.
// Latency: accept edge, 32 shift-add edges, then one HI/LO write edge; Done pulses the cycle after.
// Backpressure: no queue; Start is ignored while Busy, and mfhi/mflo reads see Stall while Busy.
module hilo_mult_sequencer (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [2:0]  OpSel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Flush,
    input  logic        RdReq,
    input  logic        RdSel,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic [31:0] RdData,
    output logic        Busy,
    output logic        Stall,
    output logic        Done
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MADD  = 3'b010;
    localparam logic [2:0] OP_MSUB  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_ACCUM = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_cnt;
    logic [2:0]  r_op;
    logic        r_neg;
    logic [63:0] r_mcand;
    logic [31:0] r_mplier;
    logic [63:0] r_prod;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_idle;
    logic        w_req_ok;
    logic        w_accept;
    logic        w_mt_hi;
    logic        w_mt_lo;
    logic        w_signed;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [63:0] w_p;
    logic [63:0] w_acc;
    logic [63:0] w_result;
    logic        w_write;

    assign w_idle   = (r_state == S_IDLE);
    // Flush beats any Start in IDLE, including the single-cycle moves.
    assign w_req_ok = w_idle & Start & ~Flush;
    assign w_accept = w_req_ok & ~OpSel[2];
    assign w_mt_hi  = w_req_ok & (OpSel == OP_MTHI);
    assign w_mt_lo  = w_req_ok & (OpSel == OP_MTLO);

    // Only multu works on raw operands; the other three multiply magnitudes and fix the sign later.
    assign w_signed = (OpSel != OP_MULTU);
    assign w_a_mag  = (w_signed && A[31]) ? (~A + 32'd1) : A;
    assign w_b_mag  = (w_signed && B[31]) ? (~B + 32'd1) : B;

    assign w_p   = r_neg ? (~r_prod + 64'd1) : r_prod;
    assign w_acc = {r_hi, r_lo};

    // The write edge is the one leaving ACCUM, unless a flush abandons it.
    assign w_write = (r_state == S_ACCUM) & ~Flush;

    // Select what lands in {HI,LO} for the latched operation.
    always_comb begin
        w_result = w_p;
        case (r_op)
            OP_MADD: w_result = w_acc + w_p;
            OP_MSUB: w_result = w_acc - w_p;
            default: w_result = w_p;
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic: IDLE -> CALC x32 -> ACCUM -> IDLE, flush returns to IDLE from either busy state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_CALC;
            S_CALC: begin
                if (Flush)               w_next = S_IDLE;
                else if (r_cnt == 5'd31) w_next = S_ACCUM;
            end
            S_ACCUM: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand latch and one shift-add step per CALC cycle.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_cnt    <= 5'd0;
            r_op     <= 3'd0;
            r_neg    <= 1'b0;
            r_mcand  <= 64'd0;
            r_mplier <= 32'd0;
            r_prod   <= 64'd0;
        end else if (w_accept) begin
            r_cnt    <= 5'd0;
            r_op     <= OpSel;
            r_neg    <= w_signed & (A[31] ^ B[31]);
            r_mcand  <= {32'd0, w_a_mag};
            r_mplier <= w_b_mag;
            r_prod   <= 64'd0;
        end else if ((r_state == S_CALC) && !Flush) begin
            if (r_mplier[0]) r_prod <= r_prod + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 5'd1;
        end
    end

    // Architectural HI/LO: multiply-class result on the ACCUM exit, otherwise mthi/mtlo from IDLE.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_write) begin
            r_hi <= w_result[63:32];
            r_lo <= w_result[31:0];
        end else if (w_mt_hi) begin
            r_hi <= A;
        end else if (w_mt_lo) begin
            r_lo <= A;
        end
    end

    // Done is a registered copy of the multiply-class write strobe.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) r_done <= 1'b0;
        else      r_done <= w_write;
    end

    assign Hi     = r_hi;
    assign Lo     = r_lo;
    assign RdData = RdSel ? r_hi : r_lo;
    assign Busy   = ~w_idle;
    assign Stall  = RdReq & ~w_idle;
    assign Done   = r_done;

endmodule

// File: doc/hilo_mult_sequencer.md
HILO_MULT_SEQUENCER -- requirements
Module: hilo_mult_sequencer

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 Clk  input  1  the single clock; all state SHALL update on the rising edge.
REQ-003 Rst  input  1  reset, asynchronous and active-low.
REQ-004 Start  input  1  request strobe, sampled on the rising edge of Clk.
REQ-005 OpSel  input  3  operation select: 000 mult, 001 multu, 010 madd, 011 msub, 100 mthi, 101 mtlo; 110 and 111 are reserved.
REQ-006 A  input  32  operand rs.
REQ-007 B  input  32  operand rt.
REQ-008 Flush  input  1  synchronous abort of an in-flight operation.
REQ-009 RdReq  input  1  pipeline mfhi/mflo read request.
REQ-010 RdSel  input  1  read select: 1 selects HI, 0 selects LO.
REQ-011 Hi  output  32  architectural HI register.
REQ-012 Lo  output  32  architectural LO register.
REQ-013 RdData  output  32  combinational: RdSel ? Hi : Lo.
REQ-014 Busy  output  1  high whenever state is not IDLE.
REQ-015 Stall  output  1  combinational: RdReq & Busy.
REQ-016 Done  output  1  one-cycle pulse marking a multiply-class write to HI/LO.

Function
REQ-017 The FSM SHALL have three states: IDLE, CALC and ACCUM.
REQ-018 In IDLE, when Start=1, Flush=0 and OpSel is 000-011:
- operands and op SHALL be latched;
- the iteration counter SHALL be cleared to 0;
- the next state SHALL be CALC.
REQ-019 In IDLE, Start with OpSel=100 SHALL write Hi<=A on that edge; OpSel=101 SHALL write Lo<=A. The state SHALL stay IDLE and Done SHALL stay 0.
REQ-020 Start with OpSel=110 or 111 SHALL be ignored.
REQ-021 CALC SHALL perform one shift-add step per cycle on the 32-bit operand magnitudes.
- After 32 CALC cycles (counter 0-31), the next state SHALL be ACCUM.
- The counter SHALL be 5 bits and the exit SHALL occur at count 31.
REQ-022 mult, madd and msub SHALL treat A and B as two's complement: operand magnitudes are taken, and the 64-bit product is negated when A[31]^B[31]=1.
REQ-023 multu SHALL treat A and B as unsigned.
REQ-024 In ACCUM, {Hi,Lo} SHALL be written on the edge that leaves ACCUM:
- mult/multu: P;
- madd: {Hi,Lo}+P;
- msub: {Hi,Lo}-P.
All arithmetic is modulo 2^64, and the next state SHALL be IDLE.
REQ-025 Done SHALL be registered and SHALL be high for exactly the one cycle following the ACCUM write edge.
REQ-026 Latency SHALL be fixed: the accept edge E0, then 32 CALC edges, then the write edge E33. Busy SHALL be high from after E0 until after E33.
REQ-027 Start while Busy=1 SHALL be ignored; there is no queue and no operand capture.
REQ-028 Flush=1 in CALC or ACCUM SHALL return the state to IDLE on that edge, with HI/LO unchanged and no Done pulse.
REQ-029 Flush=1 together with Start in IDLE SHALL win; the Start (including mthi/mtlo) SHALL be discarded.
REQ-030 Hi and Lo SHALL change only on the edges defined in REQ-019 and REQ-024.
REQ-031 RdData SHALL reflect register contents combinationally. A read in the same cycle as a write SHALL return the pre-edge value.
REQ-032 Stall SHALL depend only on RdReq and Busy, and SHALL never depend on Start.

Reset
REQ-033 Rst=0 SHALL immediately force, independent of Clk:
- state IDLE, counter 0;
- Hi=0, Lo=0;
- Busy=0, Done=0;
- all operand and product registers to 0.
REQ-034 Reset asserted mid-operation SHALL abandon the operation with no HI/LO write after release.
REQ-035 The first Start SHALL be accepted on the first rising edge after Rst returns high.

Verification
REQ-036 Signed mult: A=0xFFFFFFFE, B=0x00000003 -> Busy for 33 cycles, then Hi=0xFFFFFFFF, Lo=0xFFFFFFFA, Done high for 1 cycle.
REQ-037 multu: A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001. The same operands with mult -> Hi=0x00000000, Lo=0x00000001.
REQ-038 Accumulate sequence -> required results:
- mthi 0 and mtlo 0x10 (single cycle, Busy stays 0);
- madd A=4, B=5 -> Lo=0x24, Hi=0;
- then msub A=2, B=0x12 -> Lo=0, Hi=0;
- then msub A=1, B=1 -> Hi=Lo=0xFFFFFFFF.
REQ-039 During CALC, apply Start with OpSel=100, A=0x55 and RdReq=1 -> Stall=1 while Busy, the Start is ignored, Hi is unchanged by it, and Stall=0 the cycle after Done.
REQ-040 Flush at counter=10 of a mult -> Busy=0 next cycle, HI/LO keep prior values, no Done. Flush+Start(mtlo) in IDLE -> Lo unchanged.
REQ-041 Drive Rst=0 asynchronously mid-CALC -> Busy, Hi and Lo go to 0 before the next Clk edge. After release, a mult of 7x6 yields Lo=0x2A, Hi=0.
